// File: rtl/wdt_timer_v2.sv
// wdt_timer_v2: keyed, prescaled watchdog with optional warn stage, lock bit and status readback.
// Events act on their triggering edge (WDT_output/WDT_irq visible next cycle); bus accesses never stall.
module wdt_timer_v2 #(
  parameter int          CNT_WIDTH = 16,
  parameter int          PRESCALE  = 1,
  parameter int          RST_PULSE = 4,
  parameter logic [15:0] KICK_KEY  = 16'h5A5A
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Select,
  input  logic        Write_enable,
  input  logic [1:0]  Address,
  input  logic [15:0] Write_data_in,
  output logic [15:0] Read_data,
  output logic        WDT_output,
  output logic        WDT_irq
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, WARN, BITE} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] reload, counter, cnt_nxt;
  logic [PW-1:0]        presc, presc_nxt;
  logic [RW-1:0]        pulse_cnt, pulse_nxt;
  logic                 en, mode, lock, bite_flag, key_err;
  logic                 out_nxt, irq_nxt, bite_set, key_set;
  logic                 wr_ctrl, wr_reload, wr_kick, kick_ok, kick_bad, en_clr, tick;

  assign wr_ctrl   = Select && Write_enable && (Address == 2'd0);
  assign wr_reload = Select && Write_enable && (Address == 2'd1);
  assign wr_kick   = Select && Write_enable && (Address == 2'd2);
  assign kick_ok   = wr_kick && (Write_data_in == KICK_KEY);
  assign kick_bad  = wr_kick && !kick_ok;
  assign en_clr    = wr_ctrl && !lock && !Write_data_in[0];
  assign tick      = (presc == PW'(PRESCALE - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = counter;
    presc_nxt = presc;
    pulse_nxt = pulse_cnt;
    out_nxt   = WDT_output;
    irq_nxt   = WDT_irq;
    bite_set  = 1'b0;
    key_set   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ctrl && !lock && Write_data_in[0]) begin
          state_nxt = COUNT;
          cnt_nxt   = reload;
          presc_nxt = '0;
        end
      end
      COUNT, WARN: begin
        if (kick_bad) begin
          key_set  = 1'b1;
          bite_set = 1'b1;
        end else if (kick_ok) begin
          state_nxt = COUNT;
          cnt_nxt   = reload;
          presc_nxt = '0;
          irq_nxt   = 1'b0;
        end else if (en_clr) begin
          state_nxt = IDLE;
          presc_nxt = '0;
          irq_nxt   = 1'b0;
        end else begin
          presc_nxt = tick ? '0 : presc + PW'(1);
          // Zero on a tick is the expiry point, so the counter never wraps.
          if (tick) begin
            if (counter != '0) begin
              cnt_nxt = counter - CNT_WIDTH'(1);
            end else if (state == COUNT && mode) begin
              state_nxt = WARN;
              cnt_nxt   = reload;
              irq_nxt   = 1'b1;
            end else begin
              bite_set = 1'b1;
            end
          end
        end
      end
      BITE: begin
        if (pulse_cnt == '0) begin
          out_nxt   = 1'b0;
          cnt_nxt   = reload;
          presc_nxt = '0;
          state_nxt = en ? COUNT : IDLE;
        end else begin
          pulse_nxt = pulse_cnt - RW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bite_set) begin
      state_nxt = BITE;
      out_nxt   = 1'b1;
      irq_nxt   = 1'b0;
      pulse_nxt = RW'(RST_PULSE - 1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      counter    <= '1;
      reload     <= '1;
      presc      <= '0;
      pulse_cnt  <= '0;
      WDT_output <= 1'b0;
      WDT_irq    <= 1'b0;
      en         <= 1'b0;
      mode       <= 1'b0;
      lock       <= 1'b0;
      bite_flag  <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      counter    <= cnt_nxt;
      presc      <= presc_nxt;
      pulse_cnt  <= pulse_nxt;
      WDT_output <= out_nxt;
      WDT_irq    <= irq_nxt;
      if (wr_reload) reload <= Write_data_in[CNT_WIDTH-1:0];
      // An EN clear during the reset pulse is dropped so the pulse always completes and re-arms.
      if (wr_ctrl && !lock) begin
        en   <= (state == BITE) ? (en | Write_data_in[0]) : Write_data_in[0];
        mode <= Write_data_in[1];
        lock <= Write_data_in[2];
      end
      if (bite_set) bite_flag <= 1'b1;
      else if (wr_ctrl && Write_data_in[4]) bite_flag <= 1'b0;
      if (key_set) key_err <= 1'b1;
      else if (wr_ctrl && Write_data_in[5]) key_err <= 1'b0;
    end
  end

  always_comb begin
    Read_data = '0;
    if (Select) begin
      case (Address)
        2'd0:    Read_data = {10'd0, key_err, bite_flag, state == WARN, lock, mode, en};
        2'd1:    Read_data = 16'(reload);
        2'd3:    Read_data = 16'(counter);
        default: Read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_wdt_timer_v2.sv
// Scoreboarded bench for wdt_timer_v2: a deadline-based reference model predicts every cycle's
// read data and outputs; a negedge monitor pops and compares.
module tb_wdt_timer_v2;
  localparam int          CW    = 8;
  localparam int          P     = 2;
  localparam int          RP    = 3;
  localparam int          CMASK = (1 << CW) - 1;
  localparam logic [15:0] KEY   = 16'h5A5A;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] rdata;
  logic        wdt_out, wdt_irq;

  wdt_timer_v2 #(.CNT_WIDTH(CW), .PRESCALE(P), .RST_PULSE(RP), .KICK_KEY(KEY)) dut (
    .clock(clock), .reset(reset), .Select(sel), .Write_enable(we), .Address(addr),
    .Write_data_in(wdata), .Read_data(rdata), .WDT_output(wdt_out), .WDT_irq(wdt_irq)
  );

  always #5 clock = ~clock;

  typedef struct { int cyc; logic [15:0] rd; logic out; logic irq; } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: phases plus absolute edge timestamps instead of a live counter.
  typedef enum {M_IDLE, M_COUNT, M_WARN, M_BITE} ph_t;
  ph_t ph;
  int  edge_n, load_edge, period, bite_edge, hold_cnt, rel;
  bit  en_r, mode_r, lock_r, bflag, kerr;

  function automatic int cur_cnt();
    if (ph == M_COUNT || ph == M_WARN) return period - (edge_n - load_edge) / P;
    return hold_cnt;
  endfunction

  function automatic logic [15:0] exp_read(input logic s, input logic [1:0] a);
    logic [15:0] v;
    v = 16'h0;
    if (s) begin
      case (a)
        2'd0: begin
          v[0] = en_r; v[1] = mode_r; v[2] = lock_r;
          v[3] = (ph == M_WARN); v[4] = bflag; v[5] = kerr;
        end
        2'd1: v = 16'(rel);
        2'd3: v = 16'(cur_cnt());
        default: v = 16'h0;
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    ph = M_IDLE; edge_n = 0; load_edge = 0; period = 0; bite_edge = 0;
    hold_cnt = CMASK; rel = CMASK;
    en_r = 0; mode_r = 0; lock_r = 0; bflag = 0; kerr = 0;
  endtask

  task automatic model_step(input logic s, input logic w, input logic [1:0] a, input logic [15:0] d);
    int  e;
    bit  wr_c, kick, start_bite, kset;
    ph_t ph0;
    e = edge_n + 1;
    ph0 = ph;
    wr_c = s && w && (a == 2'd0);
    kick = s && w && (a == 2'd2);
    start_bite = 0;
    kset = 0;
    case (ph)
      M_IDLE: if (wr_c && !lock_r && d[0]) begin
        ph = M_COUNT; load_edge = e; period = rel;
      end
      M_COUNT, M_WARN: begin
        if (kick && d != KEY) begin
          hold_cnt = cur_cnt(); start_bite = 1; kset = 1;
        end else if (kick) begin
          ph = M_COUNT; load_edge = e; period = rel;
        end else if (wr_c && !lock_r && !d[0]) begin
          hold_cnt = cur_cnt(); ph = M_IDLE;
        end else if (e == load_edge + (period + 1) * P) begin
          if (ph == M_COUNT && mode_r) begin
            ph = M_WARN; load_edge = e; period = rel;
          end else begin
            hold_cnt = cur_cnt(); start_bite = 1;
          end
        end
      end
      M_BITE: if (e == bite_edge + RP) begin
        hold_cnt = rel; load_edge = e; period = rel;
        ph = en_r ? M_COUNT : M_IDLE;
      end
      default: ph = M_IDLE;
    endcase
    if (start_bite) begin
      ph = M_BITE; bite_edge = e;
    end
    if (wr_c && !lock_r) begin
      en_r   = (ph0 == M_BITE) ? (en_r | d[0]) : d[0];
      mode_r = d[1];
      lock_r = d[2];
    end
    if (wr_c && d[4]) bflag = 0;
    if (wr_c && d[5]) kerr = 0;
    if (start_bite) bflag = 1;
    if (kset) kerr = 1;
    if (s && w && a == 2'd1) rel = int'(d) & CMASK;
    edge_n = e;
  endtask

  task automatic cycle(input logic s, input logic w, input logic [1:0] a,
                       input logic [15:0] d, input logic r = 1'b1);
    exp_t x;
    @(posedge clock);
    #1;
    sel = s; we = w; addr = a; wdata = d; reset = r;
    if (!r) model_reset();
    x.cyc = cyc;
    x.rd  = exp_read(s, a);
    x.out = (ph == M_BITE);
    x.irq = (ph == M_WARN);
    sb.push_back(x);
    if (r) model_step(s, w, a, d);
    cyc++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(1'b1, 1'b0, a, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'd3, 16'h0);
  endtask

  task automatic check(input string name, input int c, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, c, got, exp);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("rdata", x.cyc, rdata, x.rd);
        check("wdt_output", x.cyc, 16'(wdt_out), 16'(x.out));
        check("wdt_irq", x.cyc, 16'(wdt_irq), 16'(x.irq));
      end
    end
  end

  initial begin
    int          r;
    logic [15:0] d;
    model_reset();
    cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
    rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
    // bite-only period, then resume and clear the flag
    wr(2'd1, 16'd3); wr(2'd0, 16'h0001); idle(16); rd(2'd0);
    wr(2'd0, 16'h0011); rd(2'd0);
    // warn then bite; then warn cancelled by a valid kick
    wr(2'd0, 16'h0000); wr(2'd0, 16'h0003); idle(20);
    wr(2'd0, 16'h0000); wr(2'd0, 16'h0003); idle(9); wr(2'd2, KEY); idle(6);
    // wrong key, then W1C of KEY_ERR
    wr(2'd0, 16'h0001); idle(2); wr(2'd2, 16'h1234); rd(2'd0); idle(4);
    wr(2'd0, 16'h0020); rd(2'd0);
    // kick on the exact expiry edge, then kicks inside the pulse
    wr(2'd1, 16'd3); wr(2'd0, 16'h0001); idle(4 * P - 1); wr(2'd2, KEY);
    idle(4 * P); wr(2'd2, KEY); wr(2'd2, 16'h1234); rd(2'd0); idle(4);
    // lock keeps EN set
    wr(2'd0, 16'h0005); wr(2'd0, 16'h0000); idle(12); rd(2'd0);
    cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
    // reload change mid-count only affects the next period
    wr(2'd1, 16'd3); wr(2'd0, 16'h0001); idle(3); wr(2'd1, 16'd10); idle(32);
    // truncated reload write, then async reset in the middle of a pulse
    wr(2'd1, 16'hAB05); rd(2'd1);
    wr(2'd2, 16'h0BAD); idle(1);
    cycle(1'b1, 1'b0, 2'd1, 16'h0, 1'b0);
    rd(2'd0); rd(2'd3);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(99));
      if (i % 300 == 299) begin
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
      end else if (r < 40) begin
        cycle(1'b0, 1'($urandom_range(1)), 2'($urandom_range(3)), 16'($urandom));
      end else if (r < 72) begin
        rd(2'($urandom_range(3)));
      end else if (r < 79) begin
        wr(2'd2, KEY);
      end else if (r < 81) begin
        wr(2'd2, 16'($urandom));
      end else if (r < 90) begin
        d = 16'($urandom);
        d[2] = ($urandom_range(7) == 0);
        wr(2'd0, d);
      end else begin
        d = 16'($urandom_range(7));
        if ($urandom_range(3) == 0) d = 16'($urandom);
        wr(2'd1, d);
      end
    end

    cycle(1'b0, 1'b0, 2'd0, 16'h0);
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
